otter_csr: RTL and testbench

Machine-mode CSR file and interrupt front end for the multi-cycle OTTER MCU. It sits directly downstream of the control-unit FSM and consumes its `csr_WE`, `int_taken` and `mret_exec` strobes. It synchronises and latches the external interrupt line and returns a gated `intr_pending` request to the FSM. It also supplies `mtvec` and `mepc` to the PC source mux for trap entry and `mret`.

---
 rtl/otter_csr_if.sv | 23 ++
 rtl/otter_csr.sv | 78 +++++++
 tb/tb_otter_csr.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/otter_csr_if.sv
// otter_csr_if: strobe, address/data and trap-vector signals between the OTTER CU and its CSR file.
interface otter_csr_if;
  logic        INTR;
  logic        csr_WE;
  logic        int_taken;
  logic        mret_exec;
  logic [11:0] addr;
  logic [31:0] wd;
  logic [31:0] pc;
  logic [31:0] rd;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mie;
  logic        intr_pending;
  modport master (
    output INTR, csr_WE, int_taken, mret_exec, addr, wd, pc,
    input  rd, mtvec, mepc, mie, intr_pending
  );
  modport slave (
    input  INTR, csr_WE, int_taken, mret_exec, addr, wd, pc,
    output rd, mtvec, mepc, mie, intr_pending
  );
endinterface

// File: rtl/otter_csr.sv
// otter_csr: machine-mode CSR file and interrupt front end for the OTTER MCU; define OTTER_CSR_MCYCLE_EN to add read-only mcycle/mcycleh.
module otter_csr #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic       CLK,
  input  logic       RST,
  otter_csr_if.slave bus
);
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MCYCLE  = 12'hB00;
  localparam logic [11:0] A_MCYCLEH = 12'hB80;
  logic        r_s1, r_s2, r_s3, r_pend, r_mie, r_mpie;
  logic [31:0] r_mtvec, r_mepc, r_mcause;
  logic [31:0] w_cyc_lo, w_cyc_hi;
  logic        w_edge;
  assign w_edge = r_s2 & ~r_s3;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s3     <= 1'b0;
      r_pend   <= 1'b0;
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_mtvec  <= RESET_MTVEC & ~32'h3;
      r_mepc   <= 32'h0;
      r_mcause <= 32'h0;
    end else begin
      r_s1   <= bus.INTR;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      // a new edge outranks a same-cycle trap entry so the request is not dropped
      r_pend <= w_edge | (r_pend & ~bus.int_taken);
      if (bus.int_taken) begin
        r_mepc   <= bus.pc & ~32'h3;
        r_mcause <= 32'h8000_000B;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (bus.mret_exec) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (bus.csr_WE) begin
        if (bus.addr == A_MSTATUS) begin
          r_mie  <= bus.wd[3];
          r_mpie <= bus.wd[7];
        end
        if (bus.addr == A_MTVEC)  r_mtvec  <= bus.wd & ~32'h3;
        if (bus.addr == A_MEPC)   r_mepc   <= bus.wd & ~32'h3;
        if (bus.addr == A_MCAUSE) r_mcause <= bus.wd;
      end
    end
`ifdef OTTER_CSR_MCYCLE_EN
  logic [63:0] r_mcycle;
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_mcycle <= 64'h0;
    else     r_mcycle <= r_mcycle + 64'd1;
  assign w_cyc_lo = r_mcycle[31:0];
  assign w_cyc_hi = r_mcycle[63:32];
`else
  assign w_cyc_lo = 32'h0;
  assign w_cyc_hi = 32'h0;
`endif
  always_comb begin
    bus.rd = (bus.addr == A_MSTATUS) ? {24'h0, r_mpie, 3'b000, r_mie, 3'b000} :
             (bus.addr == A_MTVEC)   ? r_mtvec  :
             (bus.addr == A_MEPC)    ? r_mepc   :
             (bus.addr == A_MCAUSE)  ? r_mcause :
             (bus.addr == A_MCYCLE)  ? w_cyc_lo :
             (bus.addr == A_MCYCLEH) ? w_cyc_hi : 32'h0;
  end
  assign bus.mtvec        = r_mtvec;
  assign bus.mepc         = r_mepc;
  assign bus.mie          = r_mie;
  assign bus.intr_pending = r_pend & r_mie;
endmodule

// File: tb/tb_otter_csr.sv
// tb_otter_csr: scoreboard bench for otter_csr; a spec-level model predicts each cycle's outputs, a negedge monitor compares.
module tb_otter_csr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  otter_csr_if bus();
  otter_csr #(.RESET_MTVEC(32'h0000_1003)) dut (.CLK(clk), .RST(rst), .bus(bus));
  typedef struct {
    logic [31:0] rd, mtvec, mepc;
    logic        mie, ip;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  bit          m_mie, m_mpie, m_pend;
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  logic [63:0] m_cyc;
  bit          x[3];
  logic [31:0] v1;
  function automatic void check(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction
  function automatic void m_reset();
    m_mie = 0; m_mpie = 0; m_pend = 0;
    m_mtvec = 32'h0000_1000; m_mepc = 0; m_mcause = 0; m_cyc = 0;
    x[0] = 0; x[1] = 0; x[2] = 0;
  endfunction
  function automatic logic [31:0] m_rd(logic [11:0] a);
    case (a)
      12'h300: return {24'h0, m_mpie, 3'b000, m_mie, 3'b000};
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
`ifdef OTTER_CSR_MCYCLE_EN
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction
  // x[i] holds INTR as sampled i edges ago; a rise seen two samples back sets pend now
  function automatic void m_edge();
    if (rst) return;
    m_pend = (x[1] & ~x[2]) | (m_pend & !bus.int_taken);
    x[2] = x[1]; x[1] = x[0]; x[0] = bus.INTR;
    m_cyc = m_cyc + 1;
    if (bus.int_taken) begin
      m_mepc = {bus.pc[31:2], 2'b00}; m_mcause = 32'h8000_000B; m_mpie = m_mie; m_mie = 0;
    end else if (bus.mret_exec) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (bus.csr_WE) begin
      case (bus.addr)
        12'h300: begin m_mie = bus.wd[3]; m_mpie = bus.wd[7]; end
        12'h305: m_mtvec = {bus.wd[31:2], 2'b00};
        12'h341: m_mepc = {bus.wd[31:2], 2'b00};
        12'h342: m_mcause = bus.wd;
        default: ;
      endcase
    end
  endfunction
  function automatic void push();
    exp_t e;
    e.rd = m_rd(bus.addr); e.mtvec = m_mtvec; e.mepc = m_mepc;
    e.mie = m_mie; e.ip = m_pend & m_mie;
    q.push_back(e);
  endfunction
  task automatic drive(bit r, bit intr, bit we, bit it, bit mr, logic [11:0] a, logic [31:0] d, logic [31:0] p);
    @(posedge clk); #1;
    m_edge();
    rst = r;
    if (r) m_reset();
    bus.INTR = intr; bus.csr_WE = we; bus.int_taken = it; bus.mret_exec = mr;
    bus.addr = a; bus.wd = d; bus.pc = p;
    push();
  endtask
  task automatic idle(logic [11:0] a);
    drive(0, 0, 0, 0, 0, a, 32'h0, 32'h0);
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check("rd", bus.rd, e.rd);
      check("mtvec", bus.mtvec, e.mtvec);
      check("mepc", bus.mepc, e.mepc);
      check("mie", 32'(bus.mie), 32'(e.mie));
      check("intr_pending", 32'(bus.intr_pending), 32'(e.ip));
    end
  end
  initial begin
    bus.INTR = 0; bus.csr_WE = 0; bus.int_taken = 0; bus.mret_exec = 0;
    bus.addr = 12'h305; bus.wd = 0; bus.pc = 0;
    m_reset();
    drive(1, 0, 0, 0, 0, 12'h305, 0, 0);
    @(negedge clk); #1;
    check("rst_mtvec", bus.mtvec, 32'h0000_1000);
    check("rst_mepc", bus.mepc, 32'h0);
    check("rst_mie", 32'(bus.mie), 32'h0);
    check("rst_ip", 32'(bus.intr_pending), 32'h0);
    idle(12'h0);
    drive(0, 0, 1, 0, 0, 12'h305, 32'h0000_0107, 0);
    idle(12'h305);
    @(negedge clk); #1;
    check("wr_mtvec", bus.mtvec, 32'h0000_0104);
    drive(0, 0, 1, 0, 0, 12'h300, 32'hFFFF_FFFF, 0);
    idle(12'h300);
    @(negedge clk); #1;
    check("wr_mstatus", bus.rd, 32'h0000_0088);
    drive(0, 0, 1, 0, 0, 12'h7C0, 32'hDEAD_BEEF, 0);
    idle(12'h7C0);
    @(negedge clk); #1;
    check("unknown_rd", bus.rd, 32'h0);
    drive(0, 1, 0, 0, 0, 12'h300, 0, 0);
    drive(0, 1, 0, 0, 0, 12'h300, 0, 0);
    drive(0, 1, 0, 0, 0, 12'h300, 0, 0);
    @(negedge clk); #1;
    check("ip_before_3rd", 32'(bus.intr_pending), 32'h0);
    drive(0, 0, 0, 0, 0, 12'h300, 0, 0);
    @(negedge clk); #1;
    check("ip_after_3rd", 32'(bus.intr_pending), 32'h1);
    drive(0, 0, 0, 1, 0, 12'h342, 0, 32'h0000_0123);
    idle(12'h342);
    @(negedge clk); #1;
    check("trap_mepc", bus.mepc, 32'h0000_0120);
    check("trap_mcause", bus.rd, 32'h8000_000B);
    check("trap_mie", 32'(bus.mie), 32'h0);
    check("trap_ip", 32'(bus.intr_pending), 32'h0);
    drive(0, 1, 0, 0, 0, 12'h300, 0, 0);
    repeat (4) idle(12'h300);
    @(negedge clk); #1;
    check("masked_ip", 32'(bus.intr_pending), 32'h0);
    drive(0, 0, 1, 0, 0, 12'h300, 32'h8, 0);
    idle(12'h300);
    @(negedge clk); #1;
    check("unmask_ip", 32'(bus.intr_pending), 32'h1);
    drive(0, 0, 0, 1, 0, 12'h300, 0, 32'h0000_0200);
    drive(0, 0, 0, 0, 1, 12'h300, 0, 0);
    idle(12'h300);
    @(negedge clk); #1;
    check("mret_mie", 32'(bus.mie), 32'h1);
    check("mret_mstatus", bus.rd, 32'h0000_0088);
    drive(0, 0, 1, 1, 1, 12'h305, 32'hFFFF_0000, 32'h0000_0456);
    idle(12'h305);
    @(negedge clk); #1;
    check("prio_mtvec", bus.rd, 32'h0000_0104);
    check("prio_mepc", bus.mepc, 32'h0000_0454);
    check("prio_mie", 32'(bus.mie), 32'h0);
    idle(12'hB00);
    @(negedge clk); #1;
    v1 = bus.rd;
    idle(12'hB00);
    drive(0, 0, 1, 0, 0, 12'hB00, 32'h0, 0);
    idle(12'hB00);
    @(negedge clk); #1;
`ifdef OTTER_CSR_MCYCLE_EN
    check("mcycle_step", bus.rd, v1 + 32'd3);
`else
    check("mcycle_absent", bus.rd, 32'h0);
`endif
    drive(0, 0, 1, 0, 0, 12'h300, 32'h0, 0);
    drive(0, 1, 0, 0, 0, 12'h300, 0, 0);
    repeat (3) idle(12'h300);
    drive(1, 0, 0, 0, 0, 12'h300, 0, 0);
    @(negedge clk); #1;
    check("midrst_mtvec", bus.mtvec, 32'h0000_1000);
    check("midrst_ip", 32'(bus.intr_pending), 32'h0);
    idle(12'h300);
    drive(0, 0, 1, 0, 0, 12'h300, 32'h8, 0);
    idle(12'h300);
    @(negedge clk); #1;
    check("pend_lost", 32'(bus.intr_pending), 32'h0);
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] a;
      logic [31:0] sel;
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? 12'h300 : (sel == 1) ? 12'h305 : (sel == 2) ? 12'h341 :
          (sel == 3) ? 12'h342 : (sel == 4) ? 12'hB00 : (sel == 5) ? 12'hB80 :
          (sel == 6) ? 12'h300 : 12'($urandom);
      drive($urandom_range(0, 499) == 0,
            ($urandom_range(0, 5) == 0) ? ~bus.INTR : bus.INTR,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0,
            a, $urandom, $urandom);
    end
    idle(12'h0);
    @(negedge clk); #1;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
